// File: rtl/code_entry_display.sv
// Code-entry digit store with backspace, invalid-digit flagging and an active-low
// 7-segment display with a blinking cursor and optional digit masking.
module code_entry_display #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLINK_CYCLES = 25000000,
  parameter int unsigned CNT_W        = $clog2(NUM_DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      sys_reset_n,
  input  logic                      restart_pulse,
  input  logic                      store_digit_pulse,
  input  logic                      backspace_pulse,
  input  logic [3:0]                current_digit,
  input  logic                      mask_en,
  output logic [4*NUM_DIGITS-1:0]   entered_code,
  output logic [CNT_W-1:0]          digit_count,
  output logic                      code_full,
  output logic                      invalid_digit,
  output logic [7*NUM_DIGITS-1:0]   hex_segs
);

  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'h3F;
  localparam logic [6:0] SEG_CURSOR = 7'h77;

  function automatic logic [7*NUM_DIGITS-1:0] reset_segs();
    logic [7*NUM_DIGITS-1:0] s;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      s[7*k +: 7] = (k == NUM_DIGITS - 1) ? SEG_CURSOR : SEG_BLANK;
    end
    return s;
  endfunction

  localparam logic [7*NUM_DIGITS-1:0] SEGS_RST = reset_segs();

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    full_q, full_d;
  logic                    invalid_q, invalid_d;
  logic [BW-1:0]           blink_q, blink_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] segs_q, segs_d;
  logic                    accept;
  int unsigned             cnt;

  // Command decode: restart beats backspace beats store.
  always_comb begin
    code_d    = code_q;
    count_d   = count_q;
    invalid_d = 1'b0;
    accept    = 1'b0;
    cnt       = 32'(count_q);
    if (restart_pulse) begin
      code_d  = '0;
      count_d = '0;
      accept  = 1'b1;
    end else if (backspace_pulse) begin
      if (cnt != 0) begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          if (k == NUM_DIGITS - cnt) code_d[4*k +: 4] = 4'h0;
        end
        count_d = count_q - CNT_W'(1);
        accept  = 1'b1;
      end
    end else if (store_digit_pulse) begin
      if (cnt < NUM_DIGITS) begin
        if (current_digit <= 4'd9) begin
          for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (k == NUM_DIGITS - 1 - cnt) code_d[4*k +: 4] = current_digit;
          end
          count_d = count_q + CNT_W'(1);
          accept  = 1'b1;
        end else begin
          invalid_d = 1'b1;
        end
      end
    end
    full_d = (count_d == CNT_W'(NUM_DIGITS));
  end

  // Cursor blink timer; any accepted edit restarts it in the visible phase.
  always_comb begin
    blink_d = blink_q + BW'(1);
    phase_d = phase_q;
    if (accept) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end
  end

  // Display image from current state; slot NUM_DIGITS-1 is leftmost.
  always_comb begin
    segs_d = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      int unsigned p;
      p = NUM_DIGITS - 1 - j;
      segs_d[7*j +: 7] = SEG_BLANK;
      if (p < 32'(count_q)) begin
        if (mask_en && (p != 32'(count_q) - 1)) segs_d[7*j +: 7] = SEG_DASH;
        else                                    segs_d[7*j +: 7] = glyph(code_q[4*j +: 4]);
      end else if ((p == 32'(count_q)) && (32'(count_q) < NUM_DIGITS) && phase_q) begin
        segs_d[7*j +: 7] = SEG_CURSOR;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      code_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      invalid_q <= 1'b0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
      segs_q    <= SEGS_RST;
    end else begin
      code_q    <= code_d;
      count_q   <= count_d;
      full_q    <= full_d;
      invalid_q <= invalid_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      segs_q    <= segs_d;
    end
  end

  assign entered_code  = code_q;
  assign digit_count   = count_q;
  assign code_full     = full_q;
  assign invalid_digit = invalid_q;
  assign hex_segs      = segs_q;

endmodule

// File: tb/tb_code_entry_display.sv
// Directed bench for code_entry_display with NUM_DIGITS=4, BLINK_CYCLES=4.
module tb_code_entry_display;

  logic        clk = 1'b0;
  logic        sys_reset_n;
  logic        restart_pulse, store_digit_pulse, backspace_pulse, mask_en;
  logic [3:0]  current_digit;
  logic [15:0] entered_code;
  logic [2:0]  digit_count;
  logic        code_full, invalid_digit;
  logic [27:0] hex_segs;

  int n_checks = 0;
  int n_fail   = 0;

  code_entry_display #(.NUM_DIGITS(4), .BLINK_CYCLES(4)) dut (
    .clk               (clk),
    .sys_reset_n       (sys_reset_n),
    .restart_pulse     (restart_pulse),
    .store_digit_pulse (store_digit_pulse),
    .backspace_pulse   (backspace_pulse),
    .current_digit     (current_digit),
    .mask_en           (mask_en),
    .entered_code      (entered_code),
    .digit_count       (digit_count),
    .code_full         (code_full),
    .invalid_digit     (invalid_digit),
    .hex_segs          (hex_segs)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] segs4(input logic [6:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [3:0] d);
    current_digit     = d;
    store_digit_pulse = 1'b1;
    step(1);
    store_digit_pulse = 1'b0;
  endtask

  task automatic do_backspace();
    backspace_pulse = 1'b1;
    step(1);
    backspace_pulse = 1'b0;
  endtask

  task automatic do_restart();
    restart_pulse = 1'b1;
    step(1);
    restart_pulse = 1'b0;
  endtask

  initial begin
    sys_reset_n       = 1'b0;
    restart_pulse     = 1'b0;
    store_digit_pulse = 1'b0;
    backspace_pulse   = 1'b0;
    current_digit     = 4'h0;
    mask_en           = 1'b0;
    #12;
    check("rst_code",  64'(entered_code), 64'h0);
    check("rst_count", 64'(digit_count), 64'd0);
    check("rst_full",  64'(code_full), 64'd0);
    check("rst_inv",   64'(invalid_digit), 64'd0);
    check("rst_segs",  64'(hex_segs), 64'(segs4(7'h77, 7'h7F, 7'h7F, 7'h7F)));
    @(negedge clk);
    sys_reset_n = 1'b1;

    // Fill with 1,2,3,4
    do_store(4'd1); do_store(4'd2); do_store(4'd3); do_store(4'd4);
    check("fill_code",  64'(entered_code), 64'h1234);
    check("fill_count", 64'(digit_count), 64'd4);
    check("fill_full",  64'(code_full), 64'd1);
    step(1);
    check("fill_segs",  64'(hex_segs), 64'(segs4(7'h79, 7'h24, 7'h30, 7'h19)));

    // Restart and watch the cursor blink
    do_restart();
    check("rs_code",  64'(entered_code), 64'h0);
    check("rs_count", 64'(digit_count), 64'd0);
    check("rs_full",  64'(code_full), 64'd0);
    step(1);
    check("blink_on1",  64'(hex_segs), 64'(segs4(7'h77, 7'h7F, 7'h7F, 7'h7F)));
    step(3);
    check("blink_on4",  64'(hex_segs), 64'(segs4(7'h77, 7'h7F, 7'h7F, 7'h7F)));
    step(1);
    check("blink_off1", 64'(hex_segs), 64'(segs4(7'h7F, 7'h7F, 7'h7F, 7'h7F)));
    step(3);
    check("blink_off4", 64'(hex_segs), 64'(segs4(7'h7F, 7'h7F, 7'h7F, 7'h7F)));
    step(1);
    check("blink_on_again", 64'(hex_segs), 64'(segs4(7'h77, 7'h7F, 7'h7F, 7'h7F)));

    // Backspace on empty is ignored
    do_backspace();
    check("bs_empty_count", 64'(digit_count), 64'd0);
    check("bs_empty_code",  64'(entered_code), 64'h0);

    // 9,8, backspace, 7
    do_store(4'd9); do_store(4'd8);
    check("s98_code", 64'(entered_code), 64'h9800);
    do_backspace();
    check("bs_code",  64'(entered_code), 64'h9000);
    check("bs_count", 64'(digit_count), 64'd1);
    do_store(4'd7);
    check("s97_code",  64'(entered_code), 64'h9700);
    check("s97_count", 64'(digit_count), 64'd2);

    // Invalid digit at count=1
    do_restart();
    do_store(4'd9);
    do_store(4'hA);
    check("inv_pulse", 64'(invalid_digit), 64'd1);
    check("inv_code",  64'(entered_code), 64'h9000);
    check("inv_count", 64'(digit_count), 64'd1);
    step(1);
    check("inv_clear", 64'(invalid_digit), 64'd0);

    // Store when full is ignored without an invalid pulse
    do_store(4'd1); do_store(4'd2); do_store(4'd3);
    check("full2_code", 64'(entered_code), 64'h9123);
    do_store(4'd5);
    check("ovf_code",  64'(entered_code), 64'h9123);
    check("ovf_count", 64'(digit_count), 64'd4);
    check("ovf_inv",   64'(invalid_digit), 64'd0);

    // Masked display
    do_restart();
    mask_en = 1'b1;
    do_store(4'd9); do_store(4'd8); do_store(4'd7);
    step(1);
    check("mask3_segs", 64'(hex_segs), 64'(segs4(7'h3F, 7'h3F, 7'h78, 7'h77)));
    do_store(4'd6);
    step(1);
    check("mask4_segs", 64'(hex_segs), 64'(segs4(7'h3F, 7'h3F, 7'h3F, 7'h02)));
    mask_en = 1'b0;

    // Asynchronous reset mid-cycle with count=3
    do_restart();
    do_store(4'd1); do_store(4'd2); do_store(4'd3);
    check("pre_arst_count", 64'(digit_count), 64'd3);
    #2;
    sys_reset_n = 1'b0;
    #1;
    check("arst_code",  64'(entered_code), 64'h0);
    check("arst_count", 64'(digit_count), 64'd0);
    check("arst_full",  64'(code_full), 64'd0);
    check("arst_inv",   64'(invalid_digit), 64'd0);
    check("arst_segs",  64'(hex_segs), 64'(segs4(7'h77, 7'h7F, 7'h7F, 7'h7F)));
    @(negedge clk);
    sys_reset_n = 1'b1;

    // Restart wins over a simultaneous store
    do_store(4'd4);
    check("pre_rs_code", 64'(entered_code), 64'h4000);
    restart_pulse = 1'b1; store_digit_pulse = 1'b1; current_digit = 4'd5;
    step(1);
    restart_pulse = 1'b0; store_digit_pulse = 1'b0;
    check("rs_store_code",  64'(entered_code), 64'h0);
    check("rs_store_count", 64'(digit_count), 64'd0);

    // Backspace wins over a simultaneous store
    do_store(4'd3);
    backspace_pulse = 1'b1; store_digit_pulse = 1'b1; current_digit = 4'd5;
    step(1);
    backspace_pulse = 1'b0; store_digit_pulse = 1'b0;
    check("bs_store_code",  64'(entered_code), 64'h0);
    check("bs_store_count", 64'(digit_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
